// File: rtl/deserializador.sv
// Serial-to-parallel front end for the 8x8 queue: assembles MSB-first words
// from a strobed bit stream and offers each one to the queue's enqueue side.
module deserializador #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned QUEUE_DEPTH = 8
) (
  input  logic              clock1M,
  input  logic              reset,
  input  logic              data_in,
  input  logic              write_in,
  input  logic [3:0]        len_in,
  input  logic              ack_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_ready,
  output logic              status_out
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    OFFER   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [DATA_W-1:0]   data_out_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                queue_full;

  // Occupancy above the nominal depth is treated as full.
  assign queue_full = (len_in >= 4'(QUEUE_DEPTH));

  // Next-state, shift register and word capture.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    cnt_nxt      = cnt;
    data_out_nxt = data_out;
    case (state)
      COLLECT: begin
        if (write_in) begin
          shreg_nxt = {shreg[DATA_W-2:0], data_in};
          if (cnt == CNT_W'(DATA_W - 1)) begin
            cnt_nxt      = '0;
            data_out_nxt = {shreg[DATA_W-2:0], data_in};
            state_nxt    = queue_full ? HOLD : OFFER;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (!queue_full) state_nxt = OFFER;
      end
      OFFER: begin
        // A transfer wins over a queue that fills in the same cycle.
        if (ack_in)          state_nxt = COLLECT;
        else if (queue_full) state_nxt = HOLD;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Flow-control outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state      <= COLLECT;
      shreg      <= '0;
      cnt        <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
      status_out <= 1'b1;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      data_out   <= data_out_nxt;
      data_ready <= (state_nxt == OFFER);
      status_out <= (state_nxt == COLLECT);
    end
  end

endmodule

// File: tb/tb_deserializador.sv
// Randomized and directed self-checking bench for deserializador against a
// queue-based behavioural model of the bit source / word sink handshake.
module tb_deserializador;

  logic       clock1M;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic [3:0] len_in;
  logic       ack_in;
  logic [7:0] data_out;
  logic       data_ready;
  logic       status_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: bits collected so far and the expected outputs.
  bit       m_bits[$];
  logic [7:0] m_dout;
  logic       m_ready;
  logic       m_status;

  logic [7:0] got_words[$];

  deserializador dut (
    .clock1M    (clock1M),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .len_in     (len_in),
    .ack_in     (ack_in),
    .data_out   (data_out),
    .data_ready (data_ready),
    .status_out (status_out)
  );

  initial clock1M = 1'b0;
  always #5 clock1M = ~clock1M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_dout   = 8'h00;
    m_ready  = 1'b0;
    m_status = 1'b1;
  endtask

  // Outputs before the edge decide which rule applies on that edge.
  task automatic model_edge(input bit w, input bit d, input int len, input bit ack);
    bit full;
    logic [7:0] word;
    full = (len >= 8);
    if (m_status) begin
      if (w) begin
        m_bits.push_back(d);
        if (m_bits.size() == 8) begin
          word = 8'h00;
          foreach (m_bits[i]) word = {word[6:0], m_bits[i]};
          m_bits.delete();
          m_dout   = word;
          m_status = 1'b0;
          m_ready  = !full;
        end
      end
    end else if (m_ready) begin
      if (ack) begin
        m_ready  = 1'b0;
        m_status = 1'b1;
      end else if (full) begin
        m_ready = 1'b0;
      end
    end else if (!full) begin
      m_ready = 1'b1;
    end
  endtask

  // One clock: drive, advance model, compare just after the edge.
  task automatic cyc(input bit w, input bit d, input int len, input bit ack);
    write_in = w;
    data_in  = d;
    len_in   = 4'(len);
    ack_in   = ack;
    @(posedge clock1M);
    model_edge(w, d, len, ack);
    #1;
    check("data_out", 32'(data_out), 32'(m_dout));
    check("data_ready", 32'(data_ready), 32'(m_ready));
    check("status_out", 32'(status_out), 32'(m_status));
    if (data_ready) got_words.push_back(data_out);
  endtask

  // Eight back-to-back bits, MSB first, regardless of flow control.
  task automatic send_raw(input logic [7:0] word, input int len, input bit ack);
    for (int i = 7; i >= 0; i--) cyc(1'b1, word[i], len, ack);
  endtask

  // Source that only presents a bit while the block is accepting.
  task automatic send_fc(input logic [7:0] word, input int len, input bit ack);
    int idx = 7;
    int guard = 0;
    while (idx >= 0 && guard < 40) begin
      if (status_out) begin
        cyc(1'b1, word[idx], len, ack);
        idx--;
      end else begin
        cyc(1'($urandom), 1'($urandom), len, ack);
      end
      guard++;
    end
    if (idx >= 0) check("send_timeout", 32'(idx), 32'hFFFF_FFFF);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #3;
    check("rst_dout", 32'(data_out), 32'h0);
    check("rst_ready", 32'(data_ready), 32'h0);
    check("rst_status", 32'(status_out), 32'h1);
    @(posedge clock1M);
    #2;
    reset = 1'b1;
  endtask

  logic [7:0] exp_words[4];

  initial begin
    reset    = 1'b1;
    data_in  = 1'b0;
    write_in = 1'b0;
    len_in   = 4'd0;
    ack_in   = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Contiguous bits, immediate transfer.
    send_raw(8'hA5, 0, 1'b1);
    check("t1_ready", 32'(data_ready), 32'h1);
    check("t1_dout", 32'(data_out), 32'hA5);
    cyc(1'b0, 1'b0, 0, 1'b1);
    check("t1_status", 32'(status_out), 32'h1);
    check("t1_ready_drop", 32'(data_ready), 32'h0);

    // Gaps between bits leave the partial word intact.
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b1, 1'((8'hA5 >> i) & 8'h01), 0, 1'b1);
      if (i != 0) cyc(1'b0, 1'b1, 0, 1'b1);
    end
    check("t2_dout", 32'(data_out), 32'hA5);
    cyc(1'b0, 1'b0, 0, 1'b1);

    // Full queue holds the word until space appears.
    send_raw(8'h3C, 8, 1'b1);
    check("t3_hold_ready", 32'(data_ready), 32'h0);
    check("t3_hold_status", 32'(status_out), 32'h0);
    cyc(1'b1, 1'b1, 12, 1'b1);
    check("t3_hold_over", 32'(data_ready), 32'h0);
    cyc(1'b0, 1'b0, 7, 1'b0);
    check("t3_offer", 32'(data_ready), 32'h1);
    check("t3_dout", 32'(data_out), 32'h3C);
    cyc(1'b0, 1'b0, 7, 1'b1);

    // Bits during OFFER are ignored and do not leak into the next word.
    send_raw(8'h96, 0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'(i), 0, 1'b0);
    check("t4_dout", 32'(data_out), 32'h96);
    check("t4_ready", 32'(data_ready), 32'h1);
    cyc(1'b1, 1'b1, 0, 1'b1);
    send_raw(8'h5A, 0, 1'b1);
    check("t4_next", 32'(data_out), 32'h5A);
    cyc(1'b0, 1'b0, 0, 1'b1);

    // Asynchronous reset in the middle of a word.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 0, 1'b1);
    #2;
    do_reset();
    send_raw(8'hFF, 0, 1'b1);
    check("t5_dout", 32'(data_out), 32'hFF);
    cyc(1'b0, 1'b0, 0, 1'b1);

    // Back-to-back words with a flow-controlled source.
    exp_words[0] = 8'h01;
    exp_words[1] = 8'h80;
    exp_words[2] = 8'hFF;
    exp_words[3] = 8'h00;
    got_words.delete();
    for (int k = 0; k < 4; k++) send_fc(exp_words[k], 0, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b1);
    check("t6_count", 32'(got_words.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got_words.size()) check("t6_word", 32'(got_words[k]), 32'(exp_words[k]));
    end

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
      cyc(1'($urandom), 1'($urandom), len, ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
